// File: rtl/fetch_stage_pkg.sv
// Shared pipeline types for the fetch stage: FSM states, bubble encoding and the IF/ID bundle.
// The IF/ID bundle is also consumed by decode.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pcplus4;
        logic        valid;
    } if_id_t;

    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.instruction = NOP_WORD;
        b.pcplus4     = 32'h0;
        b.valid       = 1'b0;
        return b;
    endfunction

    function automatic logic word_in_range(input logic [29:0] word_idx, input int unsigned words);
        return 32'(word_idx) < 32'(words);
    endfunction

    // Index + 1 is formed in 32 bits so the last word of a 2^30-word space never wraps to 0.
    function automatic logic next_word_in_range(input logic [29:0] word_idx, input int unsigned words);
        return (32'(word_idx) + 32'd1) < 32'(words);
    endfunction

endpackage

// File: rtl/fetch_stage_next_pc_select.sv
// Combinational next-PC priority mux: branch > jump-register > jump > stall hold > PC+4.
// Redirect targets are forced word aligned.
module next_pc_select (
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_reg,
    input  logic [31:0] jump_reg_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] next_pc,
    output logic [31:0] seq_pc,
    output logic        redirect
);

    always_comb begin
        seq_pc   = pc + 32'd4;
        redirect = branch_taken | jump_reg | jump;
        next_pc  = seq_pc;
        if (branch_taken) begin
            next_pc = {branch_target[31:2], 2'b00};
        end else if (jump_reg) begin
            next_pc = {jump_reg_target[31:2], 2'b00};
        end else if (jump) begin
            next_pc = {jump_target[31:2], 2'b00};
        end else if (stall) begin
            next_pc = pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, START/RUN/HALT FSM and the IF/ID register.
// Define FETCH_PERF_CNT_EN to add the FetchCount/BubbleCount performance counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 128
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic [31:0] IMemAddress,
    input  logic [31:0] IMemInstruction,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic        Halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    if_id_t       if_id_q, if_id_d;
    logic         halted_q, halted_d;

    logic [31:0]  next_pc;
    logic [31:0]  seq_pc;
    logic         redirect;

    next_pc_select u_next_pc_select (
        .pc              (pc_q),
        .stall           (Stall),
        .branch_taken    (BranchTaken),
        .branch_target   (BranchTarget),
        .jump_reg        (JumpReg),
        .jump_reg_target (JumpRegTarget),
        .jump            (Jump),
        .jump_target     (JumpTarget),
        .next_pc         (next_pc),
        .seq_pc          (seq_pc),
        .redirect        (redirect)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if_id_d = if_id_q;
        case (state_q)
            START: begin
                state_d = RUN;
                pc_d    = RESET_PC;
                if_id_d = if_id_bubble();
            end
            RUN: begin
                if (redirect) begin
                    if_id_d = if_id_bubble();
                    if (word_in_range(next_pc[31:2], IMEM_WORDS)) begin
                        pc_d = next_pc;
                    end else begin
                        state_d = HALT;
                    end
                end else begin
                    if (Flush) begin
                        if_id_d = if_id_bubble();
                    end else if (!Stall) begin
                        if_id_d.instruction = IMemInstruction;
                        if_id_d.pcplus4     = seq_pc;
                        if_id_d.valid       = 1'b1;
                    end
                    // Past the end of memory the PC parks on the last word.
                    if (!Stall) begin
                        if (next_word_in_range(pc_q[31:2], IMEM_WORDS)) begin
                            pc_d = next_pc;
                        end else begin
                            state_d = HALT;
                        end
                    end
                end
            end
            HALT: begin
                if_id_d = if_id_bubble();
                if (redirect && word_in_range(next_pc[31:2], IMEM_WORDS)) begin
                    pc_d    = next_pc;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = START;
                pc_d    = RESET_PC;
                if_id_d = if_id_bubble();
            end
        endcase
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= START;
            pc_q     <= RESET_PC;
            if_id_q  <= if_id_bubble();
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            if_id_q  <= if_id_d;
            halted_q <= halted_d;
        end
    end

    assign IMemAddress       = pc_q;
    assign IF_ID_Instruction = if_id_q.instruction;
    assign IF_ID_PCPlus4     = if_id_q.pcplus4;
    assign IF_ID_Valid       = if_id_q.valid;
    assign Halted            = halted_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] bubble_count_q, bubble_count_d;
    logic        load_en;

    // A stall in RUN without flush or redirect is a hold, not a load.
    always_comb begin
        load_en        = (state_q != START) &&
                         !((state_q == RUN) && !redirect && !Flush && Stall);
        fetch_count_d  = fetch_count_q + 32'((load_en && if_id_d.valid) ? 1 : 0);
        bubble_count_d = bubble_count_q + 32'((load_en && !if_id_d.valid) ? 1 : 0);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_count_q  <= 32'h0;
            bubble_count_q <= 32'h0;
        end else begin
            fetch_count_q  <= fetch_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign FetchCount  = fetch_count_q;
    assign BubbleCount = bubble_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage; memory word i holds i*3.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset, Stall, Flush, BranchTaken, JumpReg, Jump;
    logic [31:0] BranchTarget, JumpRegTarget, JumpTarget;
    logic [31:0] IMemAddress, IMemInstruction, IF_ID_Instruction, IF_ID_PCPlus4;
    logic        IF_ID_Valid, Halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount, BubbleCount;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        rst, st, fl, br;
        logic [31:0] brt;
        logic        jr;
        logic [31:0] jrt;
        logic        j;
        logic [31:0] jt;
    } stim_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
    } obs_t;

    obs_t exp_q[$];

    always #5 Clk = ~Clk;

    assign IMemInstruction = {2'b00, IMemAddress[31:2]} * 32'd3;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (128)
    ) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .Stall             (Stall),
        .Flush             (Flush),
        .BranchTaken       (BranchTaken),
        .BranchTarget      (BranchTarget),
        .JumpReg           (JumpReg),
        .JumpRegTarget     (JumpRegTarget),
        .Jump              (Jump),
        .JumpTarget        (JumpTarget),
        .IMemAddress       (IMemAddress),
        .IMemInstruction   (IMemInstruction),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_PCPlus4     (IF_ID_PCPlus4),
        .IF_ID_Valid       (IF_ID_Valid),
        .Halted            (Halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .FetchCount        (FetchCount),
        .BubbleCount       (BubbleCount)
`endif
    );

    function automatic stim_t mk_stim(input logic rst, st, fl, br, input logic [31:0] brt,
                                      input logic jr, input logic [31:0] jrt,
                                      input logic j, input logic [31:0] jt);
        stim_t s;
        s.rst = rst; s.st = st; s.fl = fl; s.br = br; s.brt = brt;
        s.jr = jr; s.jrt = jrt; s.j = j; s.jt = jt;
        return s;
    endfunction

    function automatic obs_t mk_obs(input logic [31:0] addr, instr, pc4, input logic valid, halted);
        obs_t o;
        o.addr = addr; o.instr = instr; o.pc4 = pc4; o.valid = valid; o.halted = halted;
        return o;
    endfunction

    function automatic obs_t observe();
        return mk_obs(IMemAddress, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, Halted);
    endfunction

    task automatic apply(input stim_t s);
        Reset = s.rst; Stall = s.st; Flush = s.fl;
        BranchTaken = s.br; BranchTarget = s.brt;
        JumpReg = s.jr; JumpRegTarget = s.jrt;
        Jump = s.j; JumpTarget = s.jt;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(mk_stim(1, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_obs(32'h00, 0, 0, 0, 0));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_obs(32'h00, 0, 0, 0, 0));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_obs(32'h04, 0, 32'h04, 1, 0));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_obs(32'h08, 3, 32'h08, 1, 0));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_obs(32'h0C, 6, 32'h0C, 1, 0));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_obs(32'h10, 9, 32'h10, 1, 0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset[%0d] got addr=%h ins=%h pc4=%h v=%b h=%b want addr=%h ins=%h pc4=%h v=%b h=%b",
                         i, got.addr, got.instr, got.pc4, got.valid, got.halted,
                         want.addr, want.instr, want.pc4, want.valid, want.halted);
            end else begin
                $display("ok reset[%0d] addr=%h ins=%h pc4=%h v=%b h=%b",
                         i, got.addr, got.instr, got.pc4, got.valid, got.halted);
            end
        end
    endtask

    task automatic test_stall();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        for (int k = 0; k < 3; k++) begin
            s.push_back(mk_stim(0, 1, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_obs(32'h10, 9, 32'h10, 1, 0));
        end
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0)); e.push_back(mk_obs(32'h14, 12, 32'h14, 1, 0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL stall[%0d] got addr=%h ins=%h pc4=%h v=%b h=%b want addr=%h ins=%h pc4=%h v=%b h=%b",
                         i, got.addr, got.instr, got.pc4, got.valid, got.halted,
                         want.addr, want.instr, want.pc4, want.valid, want.halted);
            end else begin
                $display("ok stall[%0d] addr=%h ins=%h pc4=%h v=%b h=%b",
                         i, got.addr, got.instr, got.pc4, got.valid, got.halted);
            end
        end
    endtask

    task automatic test_redirect();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(mk_stim(0, 0, 0, 1, 32'h40, 0, 0, 1, 32'h80));  e.push_back(mk_obs(32'h40, 0, 0, 0, 0));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0));            e.push_back(mk_obs(32'h44, 48, 32'h44, 1, 0));
        s.push_back(mk_stim(0, 0, 0, 1, 32'h43, 0, 0, 0, 0));       e.push_back(mk_obs(32'h40, 0, 0, 0, 0));
        s.push_back(mk_stim(0, 1, 0, 0, 0, 1, 32'h100, 0, 0));      e.push_back(mk_obs(32'h100, 0, 0, 0, 0));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 1, 32'h30, 1, 32'h20));  e.push_back(mk_obs(32'h30, 0, 0, 0, 0));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0));            e.push_back(mk_obs(32'h34, 36, 32'h34, 1, 0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL redirect[%0d] got addr=%h ins=%h pc4=%h v=%b h=%b want addr=%h ins=%h pc4=%h v=%b h=%b",
                         i, got.addr, got.instr, got.pc4, got.valid, got.halted,
                         want.addr, want.instr, want.pc4, want.valid, want.halted);
            end else begin
                $display("ok redirect[%0d] addr=%h ins=%h pc4=%h v=%b h=%b",
                         i, got.addr, got.instr, got.pc4, got.valid, got.halted);
            end
        end
    endtask

    task automatic test_halt();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 1, 32'h1F4));      e.push_back(mk_obs(32'h1F4, 0, 0, 0, 0));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0));            e.push_back(mk_obs(32'h1F8, 375, 32'h1F8, 1, 0));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0));            e.push_back(mk_obs(32'h1FC, 378, 32'h1FC, 1, 0));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0));            e.push_back(mk_obs(32'h1FC, 381, 32'h200, 1, 1));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0));            e.push_back(mk_obs(32'h1FC, 0, 0, 0, 1));
        s.push_back(mk_stim(0, 1, 0, 0, 0, 0, 0, 0, 0));            e.push_back(mk_obs(32'h1FC, 0, 0, 0, 1));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 1, 32'h200));      e.push_back(mk_obs(32'h1FC, 0, 0, 0, 1));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 1, 32'h24, 0, 0));       e.push_back(mk_obs(32'h24, 0, 0, 0, 0));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0));            e.push_back(mk_obs(32'h28, 27, 32'h28, 1, 0));
        s.push_back(mk_stim(0, 0, 0, 1, 32'h400, 0, 0, 0, 0));      e.push_back(mk_obs(32'h28, 0, 0, 0, 1));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 1, 32'h24, 0, 0));       e.push_back(mk_obs(32'h24, 0, 0, 0, 0));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0));            e.push_back(mk_obs(32'h28, 27, 32'h28, 1, 0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL halt[%0d] got addr=%h ins=%h pc4=%h v=%b h=%b want addr=%h ins=%h pc4=%h v=%b h=%b",
                         i, got.addr, got.instr, got.pc4, got.valid, got.halted,
                         want.addr, want.instr, want.pc4, want.valid, want.halted);
            end else begin
                $display("ok halt[%0d] addr=%h ins=%h pc4=%h v=%b h=%b",
                         i, got.addr, got.instr, got.pc4, got.valid, got.halted);
            end
        end
    endtask

    task automatic test_stall_flush();
        stim_t s[$];
        obs_t  e[$];
        obs_t  got, want;
        s.push_back(mk_stim(0, 1, 1, 0, 0, 0, 0, 0, 0));            e.push_back(mk_obs(32'h28, 0, 0, 0, 0));
        s.push_back(mk_stim(0, 0, 1, 0, 0, 0, 0, 0, 0));            e.push_back(mk_obs(32'h2C, 0, 0, 0, 0));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0));            e.push_back(mk_obs(32'h30, 33, 32'h30, 1, 0));
        s.push_back(mk_stim(0, 1, 0, 0, 0, 0, 0, 0, 0));            e.push_back(mk_obs(32'h30, 33, 32'h30, 1, 0));
        s.push_back(mk_stim(1, 1, 0, 1, 32'h80, 0, 0, 0, 0));       e.push_back(mk_obs(32'h00, 0, 0, 0, 0));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0));            e.push_back(mk_obs(32'h00, 0, 0, 0, 0));
        s.push_back(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0));            e.push_back(mk_obs(32'h04, 0, 32'h04, 1, 0));
        for (int i = 0; i < s.size(); i++) begin
            apply(s[i]);
            exp_q.push_back(e[i]);
            tick();
            got  = observe();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL stall_flush[%0d] got addr=%h ins=%h pc4=%h v=%b h=%b want addr=%h ins=%h pc4=%h v=%b h=%b",
                         i, got.addr, got.instr, got.pc4, got.valid, got.halted,
                         want.addr, want.instr, want.pc4, want.valid, want.halted);
            end else begin
                $display("ok stall_flush[%0d] addr=%h ins=%h pc4=%h v=%b h=%b",
                         i, got.addr, got.instr, got.pc4, got.valid, got.halted);
            end
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_cnt();
        logic [63:0] cnt_q[$];
        logic [63:0] want;
        apply(mk_stim(1, 0, 0, 0, 0, 0, 0, 0, 0));
        cnt_q.push_back({32'd0, 32'd0});
        tick();
        want = cnt_q.pop_front();
        checks++;
        if ({FetchCount, BubbleCount} !== want) begin
            failures++;
            $display("FAIL perf_reset got fetch=%0d bubble=%0d want fetch=%0d bubble=%0d",
                     FetchCount, BubbleCount, want[63:32], want[31:0]);
        end else begin
            $display("ok perf_reset fetch=%0d bubble=%0d", FetchCount, BubbleCount);
        end
        apply(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (11) tick();
        apply(mk_stim(0, 0, 0, 1, 32'h40, 0, 0, 0, 0));
        cnt_q.push_back({32'd10, 32'd1});
        tick();
        want = cnt_q.pop_front();
        checks++;
        if ({FetchCount, BubbleCount} !== want) begin
            failures++;
            $display("FAIL perf_counts got fetch=%0d bubble=%0d want fetch=%0d bubble=%0d",
                     FetchCount, BubbleCount, want[63:32], want[31:0]);
        end else begin
            $display("ok perf_counts fetch=%0d bubble=%0d", FetchCount, BubbleCount);
        end
        apply(mk_stim(0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        apply(mk_stim(1, 0, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_stall();
        test_redirect();
        test_halt();
        test_stall_flush();
`ifdef FETCH_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter, drives the word address into the combinational instruction memory, selects the next PC from sequential, branch, jump and jump-register sources, and holds the IF/ID pipeline register consumed by decode. Stall and flush requests from the hazard/branch logic are applied here, and the stage halts cleanly when the PC runs past the end of instruction memory.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- IMEM_WORDS, 128: instruction memory depth in words; the legal word index range is 0..IMEM_WORDS-1.
- NOP_WORD, 32'h0000_0000: bubble encoding loaded into IF/ID.
- Clk  in  1  pipeline clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- Stall  in  1  hold PC and IF/ID (load-use hazard).
- Flush  in  1  squash IF/ID contents to a bubble.
- BranchTaken  in  1  branch resolved taken in ID.
- BranchTarget  in  32  branch target byte address.
- JumpReg  in  1  jr resolved in ID.
- JumpRegTarget  in  32  register target byte address.
- Jump  in  1  j/jal decoded in ID.
- JumpTarget  in  32  jump target byte address.
- IMemAddress  out  32  byte address to instruction memory; equals PC.
- IMemInstruction  in  32  combinational read data for IMemAddress.
- IF_ID_Instruction  out  32  latched instruction.
- IF_ID_PCPlus4  out  32  PC+4 of the latched instruction.
- IF_ID_Valid  out  1  1 = real instruction, 0 = bubble.
- Halted  out  1  high while in HALT.

## Operation
- FSM states: START, RUN, HALT. Reset forces START from any state, including mid-stall or mid-redirect.
- START: PC = RESET_PC; IF/ID holds a bubble. Moves to RUN after exactly one cycle with no fetch.
- RUN, next-PC priority: BranchTaken > JumpReg > Jump > Stall (hold) > PC+4.
- Redirect targets have bits [1:0] forced to 0.
- IF/ID update:
  - Flush, or any redirect: load NOP_WORD, valid 0, PCPlus4 0.
  - Otherwise Stall: hold.
  - Otherwise: load IMemInstruction, PC+4, valid 1.
- Flush overrides Stall for IF/ID. A redirect overrides Stall for the PC.
- PC arithmetic is 32-bit modulo 2^32; there is no overflow flag.
- Entering HALT: in RUN, with no redirect and no stall, if the sequential next PC has word index PC[31:2]+1 >= IMEM_WORDS, the final in-range instruction is latched normally and the FSM enters HALT.
- A redirect to an out-of-range target enters HALT immediately.
- HALT: PC holds; IF/ID loads a bubble every cycle.
- Leaving HALT: a redirect to an in-range target loads the PC and returns to RUN, so a jr still draining through the pipeline can still return. Only Reset clears HALT otherwise.

## Timing
- Reset values: PC = RESET_PC, IF_ID_Instruction = NOP_WORD, IF_ID_PCPlus4 = 0, IF_ID_Valid = 0, Halted = 0, state START. All counters are 0.
- IMemAddress is the registered PC; there is no combinational path from the redirect inputs to it.
- Latency: an instruction at PC appears on the IF/ID outputs on the edge after the PC is presented, so the fetch-to-decode latency is 1 cycle.
- A redirect asserted in cycle n puts the target PC on IMemAddress in cycle n+1, and IF/ID shows one bubble in cycle n+1.
- A stall of k cycles freezes PC and IF/ID for exactly k edges.
- Halted rises on the edge that enters HALT.

## Configuration
- FETCH_PERF_CNT_EN defined adds two output ports:
  - FetchCount (32): increments on every valid IF/ID load.
  - BubbleCount (32): increments on every bubble load in RUN or HALT, excluding holds.
  - Both counters wrap at 2^32 and are cleared by Reset.
- FETCH_PERF_CNT_EN undefined: the ports and counters do not exist; all other behaviour is identical.

## Structure
- Shared pipeline package holds:
  - the fetch state enum (START/RUN/HALT);
  - the NOP_WORD constant;
  - the IF/ID bundle typedef (instruction, pcplus4, valid), reused by decode.
- One sub-module, next_pc_select: a combinational priority mux producing the next PC and a redirect flag. The top level holds the FSM, PC register, IF/ID register and counters.

## Test plan
- Reset, then 5 free-running cycles with memory word i = i*3 → IF_ID_Valid 0 for cycles 0-1; then IF_ID_Instruction = 0, 3, 6, with IF_ID_PCPlus4 = 4, 8, 12.
- Stall held for 3 cycles while PC = 0x10 → IMemAddress stays 0x10, IF/ID unchanged for 3 edges, then resumes with instruction 12 at PC+4 = 0x14.
- BranchTaken and Jump asserted together with BranchTarget 0x40 and JumpTarget 0x80 → next IMemAddress 0x40, one bubble; BranchTarget 0x43 → 0x40.
- Free-run to PC = 0x1FC with IMEM_WORDS 128 → instruction 381 latched valid, then Halted = 1 and bubbles; JumpReg to 0x24 → Halted 0, fetch resumes at 0x24.
- Stall and Flush together → IF_ID_Valid 0 and PC held; Reset asserted mid-stall → all outputs reach reset values on the next edge.
- With FETCH_PERF_CNT_EN: 10 sequential fetches plus 1 redirect → FetchCount 10, BubbleCount 1.
